ws2812_rx: RTL and testbench



---
 rtl/ws2812_pkg.sv | 48 ++++
 rtl/ws2812_sync.sv | 38 +++
 rtl/ws2812_rx.sv | 211 +++++++++++++++++++++
 tb/tb_ws2812_rx.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/ws2812_pkg.sv
// ============================================================================
// ws2812_pkg : shared WS2812 FSM encoding, timing defaults and pulse classifier
// Rev 1.0
// ============================================================================
`default_nettype none

package ws2812_pkg;

    typedef enum logic [1:0] {
        WAIT_LATCH = 2'd0,
        IDLE       = 2'd1,
        HIGH       = 2'd2,
        LOW        = 2'd3
    } rx_state_t;

    typedef enum logic [1:0] {
        PULSE_ZERO = 2'd0,
        PULSE_ONE  = 2'd1,
        PULSE_ERR  = 2'd2
    } pulse_class_t;

    // Defaults in cycles of a 100 MHz clock
    localparam int WS_T0H            = 40;
    localparam int WS_T1H            = 80;
    localparam int WS_LATCH          = 5000;
    localparam int WS_MIN_HIGH       = 15;
    localparam int WS_BIT_THRESH     = 60;
    localparam int WS_MAX_HIGH       = 120;
    localparam int WS_BITS_PER_PIXEL = 24;

    function automatic pulse_class_t classify_pulse(
        input int unsigned width,
        input int unsigned min_high,
        input int unsigned bit_thresh,
        input int unsigned max_high
    );
        if (width < min_high || width > max_high) begin
            return PULSE_ERR;
        end
        if (width < bit_thresh) begin
            return PULSE_ZERO;
        end
        return PULSE_ONE;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ws2812_sync.sv
// ============================================================================
// ws2812_sync : two-flop synchroniser for the raw line plus rise/fall detect
// Rev 1.0
// ============================================================================
`default_nettype none

module ws2812_sync (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic din_s,
    output logic rise,
    output logic fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= din;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign din_s = r_sync;
    assign rise  = r_sync & ~r_prev;
    assign fall  = ~r_sync & r_prev;

endmodule

`default_nettype wire

// File: rtl/ws2812_rx.sv
// ============================================================================
// ws2812_rx : WS2812 stream decoder (pulse-width bits -> 24-bit pixel words)
// Optional: WS2812_RX_STATS_EN builds saturating frame/error counters
// Rev 1.0
// ============================================================================
`default_nettype none

module ws2812_rx
    import ws2812_pkg::*;
#(
    parameter int CLK_FREQ       = 100_000_000,
    parameter int MIN_HIGH       = WS_MIN_HIGH,
    parameter int BIT_THRESH     = WS_BIT_THRESH,
    parameter int MAX_HIGH       = WS_MAX_HIGH,
    parameter int LATCH_CYCLES   = WS_LATCH,
    parameter int BITS_PER_PIXEL = WS_BITS_PER_PIXEL,
    parameter int PX_COUNT_WIDTH = 6
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      din,
    output logic                      pixel_valid,
    output logic [BITS_PER_PIXEL-1:0] pixel_data,
    output logic [PX_COUNT_WIDTH-1:0] px_index,
    output logic                      frame_done,
    output logic [PX_COUNT_WIDTH-1:0] frame_px_count,
    output logic                      bit_error,
    output logic [15:0]               frame_total,
    output logic [15:0]               error_total
);

    localparam int c_wid_w = $clog2(MAX_HIGH + 2);
    localparam int c_low_w = $clog2(LATCH_CYCLES);
    localparam int c_bit_w = $clog2(BITS_PER_PIXEL);

    localparam logic [c_wid_w-1:0]        c_width_sat = c_wid_w'(MAX_HIGH + 1);
    localparam logic [c_wid_w-1:0]        c_width_one = c_wid_w'(1);
    localparam logic [c_low_w-1:0]        c_latch_m1  = c_low_w'(LATCH_CYCLES - 1);
    localparam logic [c_low_w-1:0]        c_low_one   = c_low_w'(1);
    localparam logic [c_bit_w-1:0]        c_last_bit  = c_bit_w'(BITS_PER_PIXEL - 1);
    localparam logic [PX_COUNT_WIDTH-1:0] c_idx_max   = '1;

    // Inconsistent timing parameters keep the receiver parked in WAIT_LATCH
    localparam bit c_params_ok = (CLK_FREQ > 0) && (MIN_HIGH > 0) &&
                                 (MIN_HIGH <= BIT_THRESH) && (BIT_THRESH <= MAX_HIGH) &&
                                 (LATCH_CYCLES > 1) && (BITS_PER_PIXEL > 2);

    logic w_din_s;
    logic w_rise;
    logic w_fall;

    ws2812_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .din   (din),
        .din_s (w_din_s),
        .rise  (w_rise),
        .fall  (w_fall)
    );

    rx_state_t                 r_state;
    logic [c_wid_w-1:0]        r_width;
    logic [c_low_w-1:0]        r_low;
    logic [BITS_PER_PIXEL-2:0] r_shift;
    logic [c_bit_w-1:0]        r_bit_cnt;
    logic [PX_COUNT_WIDTH-1:0] r_index;

    logic                      r_pixel_valid;
    logic [BITS_PER_PIXEL-1:0] r_pixel_data;
    logic [PX_COUNT_WIDTH-1:0] r_px_index;
    logic                      r_frame_done;
    logic [PX_COUNT_WIDTH-1:0] r_frame_px_count;
    logic                      r_bit_error;

    pulse_class_t w_class;
    logic         w_bit;

    assign w_class = classify_pulse(32'(r_width), MIN_HIGH, BIT_THRESH, MAX_HIGH);
    assign w_bit   = (w_class == PULSE_ONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= WAIT_LATCH;
            r_width          <= '0;
            r_low            <= '0;
            r_shift          <= '0;
            r_bit_cnt        <= '0;
            r_index          <= '0;
            r_pixel_valid    <= 1'b0;
            r_pixel_data     <= '0;
            r_px_index       <= '0;
            r_frame_done     <= 1'b0;
            r_frame_px_count <= '0;
            r_bit_error      <= 1'b0;
        end else begin
            r_pixel_valid <= 1'b0;
            r_frame_done  <= 1'b0;
            r_bit_error   <= 1'b0;

            case (r_state)
                WAIT_LATCH: begin
                    if (w_din_s) begin
                        r_low <= '0;
                    end else if (r_low != c_latch_m1) begin
                        r_low <= r_low + 1'b1;
                    end else if (c_params_ok) begin
                        // Resynchronised: start a fresh frame without reporting one
                        r_state   <= IDLE;
                        r_low     <= '0;
                        r_index   <= '0;
                        r_shift   <= '0;
                        r_bit_cnt <= '0;
                    end
                end

                IDLE: begin
                    if (w_rise) begin
                        r_state <= HIGH;
                        r_width <= c_width_one;
                    end
                end

                HIGH: begin
                    if (w_fall) begin
                        r_low <= c_low_one;
                        if (w_class == PULSE_ERR) begin
                            r_state     <= WAIT_LATCH;
                            r_bit_error <= 1'b1;
                            r_shift     <= '0;
                            r_bit_cnt   <= '0;
                        end else begin
                            r_state <= LOW;
                            if (r_bit_cnt == c_last_bit) begin
                                r_pixel_valid <= 1'b1;
                                r_pixel_data  <= {r_shift, w_bit};
                                r_px_index    <= r_index;
                                r_shift       <= '0;
                                r_bit_cnt     <= '0;
                                if (r_index != c_idx_max) begin
                                    r_index <= r_index + 1'b1;
                                end
                            end else begin
                                r_shift   <= {r_shift[BITS_PER_PIXEL-3:0], w_bit};
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                            end
                        end
                    end else if (r_width != c_width_sat) begin
                        r_width <= r_width + 1'b1;
                    end
                end

                LOW: begin
                    if (w_rise) begin
                        r_state <= HIGH;
                        r_width <= c_width_one;
                    end else if (r_low != c_latch_m1) begin
                        r_low <= r_low + 1'b1;
                    end else begin
                        r_state          <= IDLE;
                        r_low            <= '0;
                        r_frame_done     <= 1'b1;
                        r_frame_px_count <= r_index;
                        r_index          <= '0;
                        r_bit_error      <= (r_bit_cnt != '0);
                        r_shift          <= '0;
                        r_bit_cnt        <= '0;
                    end
                end

                default: begin
                    r_state <= WAIT_LATCH;
                end
            endcase
        end
    end

    assign pixel_valid    = r_pixel_valid;
    assign pixel_data     = r_pixel_data;
    assign px_index       = r_px_index;
    assign frame_done     = r_frame_done;
    assign frame_px_count = r_frame_px_count;
    assign bit_error      = r_bit_error;

`ifdef WS2812_RX_STATS_EN
    logic [15:0] r_frame_total;
    logic [15:0] r_error_total;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame_total <= '0;
            r_error_total <= '0;
        end else begin
            if (r_frame_done && (r_frame_total != 16'hFFFF)) begin
                r_frame_total <= r_frame_total + 1'b1;
            end
            if (r_bit_error && (r_error_total != 16'hFFFF)) begin
                r_error_total <= r_error_total + 1'b1;
            end
        end
    end

    assign frame_total = r_frame_total;
    assign error_total = r_error_total;
`else
    assign frame_total = '0;
    assign error_total = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ws2812_rx.sv
// ============================================================================
// tb_ws2812_rx : scoreboard bench for ws2812_rx driving pulse-width streams
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ws2812_rx;
    import ws2812_pkg::*;

    localparam int LATCH_IDLE = WS_LATCH + 100;
    localparam int FAST_LO    = 25;

`ifdef WS2812_RX_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        din;
    logic        pixel_valid;
    logic [23:0] pixel_data;
    logic [5:0]  px_index;
    logic        frame_done;
    logic [5:0]  frame_px_count;
    logic        bit_error;
    logic [15:0] frame_total;
    logic [15:0] error_total;

    ws2812_rx dut (
        .clk            (clk),
        .reset          (reset),
        .din            (din),
        .pixel_valid    (pixel_valid),
        .pixel_data     (pixel_data),
        .px_index       (px_index),
        .frame_done     (frame_done),
        .frame_px_count (frame_px_count),
        .bit_error      (bit_error),
        .frame_total    (frame_total),
        .error_total    (error_total)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        pv;
        logic        fd;
        logic        be;
        logic [23:0] data;
        logic [5:0]  idx;
        logic [5:0]  cnt;
        int          due;
    } ev_t;

    ev_t sb[$];
    int  n_pass = 0;
    int  n_total = 0;
    int  exp_frames = 0;
    int  exp_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_ev(input logic pv, input logic fd, input logic be,
                           input logic [23:0] data, input logic [5:0] idx,
                           input logic [5:0] cnt, input int due);
        ev_t e;
        e.pv = pv; e.fd = fd; e.be = be;
        e.data = data; e.idx = idx; e.cnt = cnt; e.due = due;
        sb.push_back(e);
    endtask

    // Each DUT strobe must match the oldest outstanding expectation
    always @(negedge clk) begin
        ev_t e;
        if (!reset && (pixel_valid || frame_done || bit_error)) begin
            if (sb.size() == 0) begin
                check("unexpected_event", {29'b0, pixel_valid, frame_done, bit_error}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("event_kind", {29'b0, pixel_valid, frame_done, bit_error},
                      {29'b0, e.pv, e.fd, e.be});
                if (e.pv) begin
                    check("pixel_data", 32'(pixel_data), 32'(e.data));
                    check("px_index", 32'(px_index), 32'(e.idx));
                    if (e.due >= 0) check("pixel_latency", 32'(cyc), 32'(e.due));
                end
                if (e.fd) check("frame_px_count", 32'(frame_px_count), 32'(e.cnt));
            end
        end
    end

    task automatic idle_low(input int n);
        din = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_word(input logic [23:0] data, input int nbits, input bit expect_px,
                             input int idx, input int period, input bit edge_w);
        int hi;
        for (int i = nbits - 1; i >= 0; i--) begin
            if (edge_w) hi = data[i] ? ((i % 2 != 0) ? 120 : 60) : ((i % 2 != 0) ? 59 : 15);
            else        hi = data[i] ? WS_T1H : WS_T0H;
            din = 1'b1;
            repeat (hi) @(negedge clk);
            if (expect_px && i == 0) push_ev(1'b1, 1'b0, 1'b0, data, 6'(idx), 6'd0, int'(cyc) + 3);
            din = 1'b0;
            repeat ((period > 0) ? (period - hi) : FAST_LO) @(negedge clk);
        end
    endtask

    task automatic latch_frame(input int cnt, input bit partial);
        push_ev(1'b0, 1'b1, partial, 24'd0, 6'd0, 6'(cnt), -1);
        exp_frames++;
        if (partial) exp_errors++;
        idle_low(LATCH_IDLE);
    endtask

    task automatic error_pulse(input int hi);
        push_ev(1'b0, 1'b0, 1'b1, 24'd0, 6'd0, 6'd0, -1);
        exp_errors++;
        din = 1'b1;
        repeat (hi) @(negedge clk);
        din = 1'b0;
        repeat (45) @(negedge clk);
    endtask

    task automatic check_stats();
        check("frame_total", 32'(frame_total), STATS_ON ? 32'(exp_frames) : 32'd0);
        check("error_total", 32'(error_total), STATS_ON ? 32'(exp_errors) : 32'd0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        din   = 1'b0;
        reset = 1'b1;
        repeat (5) @(negedge clk);
        check("reset_strobes", {29'b0, pixel_valid, frame_done, bit_error}, 32'd0);
        check("reset_pixel_data", 32'(pixel_data), 32'd0);
        check("reset_px_index", 32'(px_index), 32'd0);
        check("reset_frame_px_count", 32'(frame_px_count), 32'd0);
        check_stats();
        reset = 1'b0;
        idle_low(LATCH_IDLE);

        // Single pixel at 125-cycle bit period, latency checked
        send_word(24'hA53C0F, 24, 1'b1, 0, 125, 1'b0);
        latch_frame(1, 1'b0);

        // Three-pixel frame
        send_word(24'hFF0000, 24, 1'b1, 0, 0, 1'b0);
        send_word(24'h00FF00, 24, 1'b1, 1, 0, 1'b0);
        send_word(24'h0000FF, 24, 1'b1, 2, 0, 1'b0);
        latch_frame(3, 1'b0);

        // Glitch just below MIN_HIGH; following pixel ignored until a full low period
        error_pulse(14);
        send_word(24'h00FF00, 24, 1'b0, 0, 0, 1'b0);
        idle_low(LATCH_IDLE);
        send_word(24'h5AC396, 24, 1'b1, 0, 0, 1'b1);
        latch_frame(1, 1'b0);

        // Just above MAX_HIGH
        error_pulse(121);
        idle_low(LATCH_IDLE);

        // Partial pixel at latch
        send_word(24'h000ABC, 12, 1'b0, 0, 0, 1'b0);
        latch_frame(0, 1'b1);

        // Transmitter-style repeated pixel
        for (int p = 0; p < 4; p++) send_word(24'h123456, 24, 1'b1, p, 125, 1'b0);
        latch_frame(4, 1'b0);
        check_stats();

        // Reset in the middle of a pixel, stream resumes at once
        send_word(24'hFFFFFF, 10, 1'b0, 0, 0, 1'b0);
        din = 1'b1;
        repeat (20) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        exp_frames = 0;
        exp_errors = 0;
        din = 1'b0;
        repeat (45) @(negedge clk);
        send_word(24'h123456, 24, 1'b0, 0, 0, 1'b0);
        idle_low(LATCH_IDLE);
        send_word(24'hC0FFEE, 24, 1'b1, 0, 0, 1'b0);
        latch_frame(1, 1'b0);
        check_stats();

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
